fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      i_full;
    logic                      i_alm_full;
    logic                      o_wren;
    logic [DATA_W-1:0]         o_wrdata;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_data, i_full, i_alm_full,
        input  req_ready, o_wren, o_wrdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, i_full, i_alm_full,
        output req_ready, o_wren, o_wrdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 128,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]  grant_q, grant_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic              space_ok;
    logic              gnt_valid;
    logic              accept;
    logic [GID_W-1:0]  pick;
    logic [GID_W-1:0]  scan_idx;
    logic              pick_found;

    function automatic logic [GID_W-1:0] inc_wrap(input logic [GID_W-1:0] v);
        if (int'(v) == NUM_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // All state registers; reset clears everything, dropping any write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            wren_q     <= 1'b0;
            wrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            wren_q     <= wren_d;
            wrdata_q   <= wrdata_d;
        end
    end

    // FIFO room check: almost-full plus a write already landing means no room this cycle.
    always_comb begin
        space_ok  = !bus.i_full && !(bus.i_alm_full && wren_q);
        gnt_valid = bus.req_valid[grant_q];
        accept    = (state_q == BURST) && gnt_valid && space_ok;
    end

    // Round-robin search: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        scan_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && bus.req_valid[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
            scan_idx = inc_wrap(scan_idx);
        end
    end

    // Next-state: grant in IDLE, count beats in BURST, release on burst limit or valid drop.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        wren_d     = accept;
        wrdata_d   = wrdata_q;
        if (accept) begin
            wrdata_d = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (beat_cnt_q + 4'd1 == BURST_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = inc_wrap(grant_q);
                    end
                end else if (!gnt_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = inc_wrap(grant_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the granted requester sees ready, and only while in BURST.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == BURST) begin
            bus.req_ready[grant_q] = space_ok;
        end
        bus.busy     = (state_q == BURST);
        bus.grant_id = grant_q;
        bus.o_wren   = wren_q;
        bus.o_wrdata = wrdata_q;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 128;
    localparam int BM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [DW-1:0] src_q [NR][$];
    logic [DW-1:0] exp_q [$];
    int            wr_cyc [$];
    int            grant_log [$];
    logic [NR-1:0] acc_mask  = '0;
    logic          busy_prev = 1'b0;
    logic          full_seen = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_drive();
        for (int n = 0; n < NR; n++) begin
            if (src_q[n].size() > 0) begin
                bus.req_valid[n]            = 1'b1;
                bus.req_data[n*DW +: DW]    = src_q[n][0];
            end else begin
                bus.req_valid[n]            = 1'b0;
            end
        end
    endtask

    task automatic push_beats(input int n, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            src_q[n].push_back({$urandom(), $urandom(), $urandom(), 32'(n*1000 + k)});
        end
        refresh_drive();
    endtask

    task automatic clear_sources();
        for (int n = 0; n < NR; n++) src_q[n].delete();
        refresh_drive();
    endtask

    task automatic sample();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] acc;
        if (reset) begin
            check("rst_wren",  DW'(bus.o_wren),    '0);
            check("rst_busy",  DW'(bus.busy),      '0);
            check("rst_ready", DW'(bus.req_ready), '0);
            exp_q.delete();
            acc_mask  = '0;
            busy_prev = 1'b0;
            full_seen = 1'b0;
        end else begin
            cyc++;
            if (full_seen) check("wren_after_full", DW'(bus.o_wren), '0);
            if (bus.o_wren) begin
                check("wr_expected", DW'(exp_q.size() > 0), DW'(1));
                if (exp_q.size() > 0) check("wr_data", bus.o_wrdata, exp_q.pop_front());
                wr_cyc.push_back(cyc);
            end
            exp_rdy = '0;
            if (bus.busy) exp_rdy[bus.grant_id] = !bus.i_full && !(bus.i_alm_full && bus.o_wren);
            check("req_ready", DW'(bus.req_ready), DW'(exp_rdy));
            if (bus.busy && !busy_prev) grant_log.push_back(int'(bus.grant_id));
            busy_prev = bus.busy;
            acc = bus.req_valid & bus.req_ready;
            for (int n = 0; n < NR; n++) begin
                if (acc[n]) exp_q.push_back(src_q[n][0]);
            end
            acc_mask  = acc;
            full_seen = bus.i_full;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int n = 0; n < NR; n++) begin
                if (acc_mask[n]) void'(src_q[n].pop_front());
            end
        end
        refresh_drive();
    endtask

    function automatic bit all_done();
        for (int n = 0; n < NR; n++) if (src_q[n].size() > 0) return 1'b0;
        return (exp_q.size() == 0) && !bus.busy;
    endfunction

    task automatic drain(input string tag, input int bound);
        int  k = 0;
        logic to;
        while (k < bound && !all_done()) begin
            tick();
            k++;
        end
        to = (k >= bound);
        check({tag, "_drain_timeout"}, DW'(to), '0);
    endtask

    task automatic wait_writes(input string tag, input int base, input int want);
        int  k = 0;
        logic to;
        while (k < 100 && (wr_cyc.size() - base) < want) begin
            tick();
            k++;
        end
        to = (k >= 100);
        check({tag, "_wait_timeout"}, DW'(to), '0);
    endtask

    task automatic check_grants(input string tag, input int gbase, input int eg[$]);
        check({tag, "_grant_cnt"}, DW'(grant_log.size() - gbase), DW'(eg.size()));
        for (int i = 0; i < eg.size(); i++) begin
            if (gbase + i < grant_log.size()) check({tag, "_grant"}, DW'(grant_log[gbase+i]), DW'(eg[i]));
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.i_full     = 1'b0;
        bus.i_alm_full = 1'b0;
        clear_sources();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int wbase;
        int gbase;
        int k;
        int eg[$];
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.i_full     = 1'b0;
        bus.i_alm_full = 1'b0;

        tick();
        check("rst_wrdata", bus.o_wrdata,        '0);
        check("rst_grant",  DW'(bus.grant_id),   '0);
        tick();
        reset = 1'b0;

        // six beats on requester 0: four back to back, one arbitration bubble, two more
        wbase = wr_cyc.size();
        gbase = grant_log.size();
        push_beats(0, 6);
        drain("t1", 100);
        check("t1_wr_cnt", DW'(wr_cyc.size() - wbase), DW'(6));
        if (wr_cyc.size() - wbase == 6) begin
            for (int i = 1; i < 6; i++) begin
                check("t1_gap", DW'(wr_cyc[wbase+i] - wr_cyc[wbase+i-1]), DW'((i == 4) ? 2 : 1));
            end
        end
        eg = '{0, 0};
        check_grants("t1", gbase, eg);

        // all four requesting with an empty FIFO
        do_reset();
        wbase = wr_cyc.size();
        gbase = grant_log.size();
        push_beats(0, 8);
        push_beats(1, 4);
        push_beats(2, 4);
        push_beats(3, 4);
        drain("t2", 200);
        check("t2_wr_cnt", DW'(wr_cyc.size() - wbase), DW'(20));
        eg = '{0, 1, 2, 3, 0};
        check_grants("t2", gbase, eg);

        // full stall in the middle of requester 2's burst
        do_reset();
        wbase = wr_cyc.size();
        gbase = grant_log.size();
        push_beats(2, 6);
        wait_writes("t3", wbase, 2);
        bus.i_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_busy",  DW'(bus.busy),     DW'(1));
            check("t3_stall_grant", DW'(bus.grant_id), DW'(2));
        end
        bus.i_full = 1'b0;
        drain("t3", 100);
        check("t3_wr_cnt", DW'(wr_cyc.size() - wbase), DW'(6));
        eg = '{2, 2};
        check_grants("t3", gbase, eg);

        // almost-full: a write in flight blocks the next beat, so writes alternate
        do_reset();
        bus.i_alm_full = 1'b1;
        wbase = wr_cyc.size();
        push_beats(1, 3);
        drain("t4", 100);
        check("t4_wr_cnt", DW'(wr_cyc.size() - wbase), DW'(3));
        if (wr_cyc.size() - wbase == 3) begin
            for (int i = 1; i < 3; i++) begin
                check("t4_gap", DW'(wr_cyc[wbase+i] - wr_cyc[wbase+i-1]), DW'(2));
            end
        end
        bus.i_alm_full = 1'b0;

        // requester 1 drops after two beats; pointer moves past it to 3 before 0
        do_reset();
        gbase = grant_log.size();
        push_beats(1, 2);
        push_beats(3, 2);
        k = 0;
        while (k < 20 && !bus.busy) begin
            tick();
            k++;
        end
        check("t5_busy_timeout", DW'(k >= 20), '0);
        push_beats(0, 2);
        drain("t5", 100);
        eg = '{1, 3, 0};
        check_grants("t5", gbase, eg);

        // asynchronous reset during a burst, then arbitration restarts at requester 0
        do_reset();
        wbase = wr_cyc.size();
        push_beats(2, 8);
        wait_writes("t6", wbase, 2);
        #2;
        check("t6_pre_wren", DW'(bus.o_wren), DW'(1));
        reset = 1'b1;
        #1;
        check("t6_async_wren",  DW'(bus.o_wren),    '0);
        check("t6_async_busy",  DW'(bus.busy),      '0);
        check("t6_async_ready", DW'(bus.req_ready), '0);
        clear_sources();
        tick();
        tick();
        reset = 1'b0;
        gbase = grant_log.size();
        wbase = wr_cyc.size();
        push_beats(2, 2);
        push_beats(0, 2);
        drain("t6", 100);
        check("t6_wr_cnt", DW'(wr_cyc.size() - wbase), DW'(4));
        eg = '{0, 2};
        check_grants("t6", gbase, eg);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
